// File: rtl/scanline_stream_buffer.sv
// Ping-pong scanline buffer between renderer and LCD sink; valid/ready pixel stream with line/frame markers.
// Optional SCANLINE_PALETTE_EN adds a bgp palette input, sampled once per line at FETCH.
module scanline_stream_buffer #(
    parameter int LINE_W    = 160,
    parameter int NUM_LINES = 144
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       line_wr_en,
    input  logic [7:0] line_wr_x,
    input  logic [1:0] line_wr_shade,
    input  logic       line_done,
`ifdef SCANLINE_PALETTE_EN
    input  logic [7:0] bgp,
`endif
    output logic       drawline,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic [1:0] pix_data,
    output logic       pix_sol,
    output logic       pix_eol,
    output logic       pix_sof,
    output logic       pix_eof,
    output logic       overflow,
    output logic       frame_done
);

    localparam int              YW     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam logic [7:0]      X_LAST = 8'(LINE_W - 1);
    localparam logic [YW-1:0]   Y_LAST = YW'(NUM_LINES - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM} state_t;

    logic [1:0]    r_mem [2][LINE_W];
    logic [1:0]    r_full;
    logic          r_wr_sel;
    logic          r_rd_sel;
    logic          r_overflow;
    logic          r_drawline;
    state_t        r_state;
    logic          r_valid;
    logic [7:0]    r_x;
    logic [YW-1:0] r_y;
    logic [1:0]    r_pix;
    logic          r_frame_done;

    logic          w_wr_ok;
    logic          w_done_ok;
    logic          w_accept;
    logic          w_line_end;
    logic          w_wr_sel_nxt;
    logic [1:0]    w_full_nxt;
    logic [7:0]    w_rd_addr;

    assign w_wr_ok      = line_wr_en && ({1'b0, line_wr_x} < 9'(LINE_W)) && !r_full[r_wr_sel];
    assign w_done_ok    = line_done && !r_full[r_wr_sel];
    assign w_accept     = r_valid && pix_ready;
    assign w_line_end   = w_accept && (r_x == X_LAST);
    assign w_wr_sel_nxt = r_wr_sel ^ w_done_ok;
    assign w_rd_addr    = (r_state == S_FETCH) ? 8'd0 : r_x + 8'd1;

    // A fill and a drain in the same cycle never hit the same buffer: one needs it empty, the other full.
    always_comb begin
        w_full_nxt = r_full;
        if (w_done_ok)  w_full_nxt[r_wr_sel] = 1'b1;
        if (w_line_end) w_full_nxt[r_rd_sel] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wr_sel][line_wr_x] <= line_wr_shade;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full     <= 2'b00;
            r_wr_sel   <= 1'b0;
            r_overflow <= 1'b0;
            r_drawline <= 1'b1;
        end else begin
            r_full     <= w_full_nxt;
            r_wr_sel   <= w_wr_sel_nxt;
            r_drawline <= !w_full_nxt[w_wr_sel_nxt];
            if (line_done && r_full[r_wr_sel]) r_overflow <= 1'b1;
        end
    end

`ifdef SCANLINE_PALETTE_EN
    logic [7:0] r_bgp;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_valid      <= 1'b0;
            r_rd_sel     <= 1'b0;
            r_x          <= 8'd0;
            r_y          <= '0;
            r_pix        <= 2'd0;
            r_frame_done <= 1'b0;
`ifdef SCANLINE_PALETTE_EN
            r_bgp        <= 8'hE4;
`endif
        end else begin
            r_frame_done <= w_line_end && (r_y == Y_LAST);
            case (r_state)
                S_IDLE: begin
                    // Looking at the next-state flag lets a line_done start the fetch one cycle earlier.
                    if (w_full_nxt[r_rd_sel]) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    r_pix   <= r_mem[r_rd_sel][w_rd_addr];
                    r_valid <= 1'b1;
                    r_state <= S_STREAM;
`ifdef SCANLINE_PALETTE_EN
                    r_bgp   <= bgp;
`endif
                end
                S_STREAM: begin
                    if (w_line_end) begin
                        r_valid  <= 1'b0;
                        r_x      <= 8'd0;
                        r_rd_sel <= ~r_rd_sel;
                        r_y      <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
                        r_state  <= w_full_nxt[~r_rd_sel] ? S_FETCH : S_IDLE;
                    end else if (w_accept) begin
                        r_x   <= r_x + 8'd1;
                        r_pix <= r_mem[r_rd_sel][w_rd_addr];
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SCANLINE_PALETTE_EN
    assign pix_data = r_bgp[{r_pix, 1'b1} -: 2];
`else
    assign pix_data = r_pix;
`endif

    assign drawline   = r_drawline;
    assign pix_valid  = r_valid;
    assign pix_sol    = r_valid && (r_x == 8'd0);
    assign pix_eol    = r_valid && (r_x == X_LAST);
    assign pix_sof    = pix_sol && (r_y == '0);
    assign pix_eof    = pix_eol && (r_y == Y_LAST);
    assign overflow   = r_overflow;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_scanline_stream_buffer.sv
// Directed bench for scanline_stream_buffer; palette scenario compiled only with SCANLINE_PALETTE_EN.
module tb_scanline_stream_buffer;

    localparam int LW = 160;
    localparam int NL = 144;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       line_wr_en = 1'b0;
    logic [7:0] line_wr_x = 8'd0;
    logic [1:0] line_wr_shade = 2'd0;
    logic       line_done = 1'b0;
`ifdef SCANLINE_PALETTE_EN
    logic [7:0] bgp = 8'hE4;
`endif
    logic       drawline, pix_valid, pix_sol, pix_eol, pix_sof, pix_eof, overflow, frame_done;
    logic       pix_ready = 1'b0;
    logic [1:0] pix_data;

    int n_checks = 0;
    int n_errors = 0;

    scanline_stream_buffer #(.LINE_W(LW), .NUM_LINES(NL)) dut (
        .clk(clk), .reset_n(reset_n),
        .line_wr_en(line_wr_en), .line_wr_x(line_wr_x), .line_wr_shade(line_wr_shade),
        .line_done(line_done),
`ifdef SCANLINE_PALETTE_EN
        .bgp(bgp),
`endif
        .drawline(drawline), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_sof(pix_sof), .pix_eof(pix_eof),
        .overflow(overflow), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset_n = 1'b0; line_wr_en = 1'b0; line_done = 1'b0; pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Writes shade (x+mode)%4 at every x, then pulses line_done; returns one cycle after the pulse.
    task automatic write_line(input int mode);
        for (int x = 0; x < LW; x++) begin
            @(posedge clk); #1;
            line_wr_en = 1'b1; line_wr_x = 8'(x); line_wr_shade = 2'((x + mode) % 4);
        end
        @(posedge clk); #1 line_wr_en = 1'b0; line_done = 1'b1;
        @(posedge clk); #1 line_done = 1'b0;
    endtask

    task automatic stream_line(input int mode, input int y, input bit toggle,
                               input logic [7:0] pal, input int npix, input int limit);
        int x = 0;
        int c = 0;
        int w = 0;
        logic [1:0] s;
        logic [5:0] got, exp;
        @(negedge clk);
        while (!pix_valid && w < limit) begin @(negedge clk); w++; end
        n_checks++;
        if (pix_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL stream_start y=%0d: pix_valid=%b, required 1 within %0d cycles", y, pix_valid, limit);
            pix_ready = 1'b0;
            return;
        end
        while (x < npix) begin
            pix_ready = toggle ? (c % 2 == 0) : 1'b1;
            s   = 2'((x + mode) % 4);
            exp = {1'b1, pal[2*s+1 -: 2], x == 0, x == LW-1, (x == 0) && (y == 0), (x == LW-1) && (y == NL-1)};
            got = {pix_valid, pix_data, pix_sol, pix_eol, pix_sof, pix_eof};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL pixel y=%0d x=%0d cyc=%0d {valid,data,sol,eol,sof,eof}: got %b required %b", y, x, c, got, exp);
            end
            @(posedge clk);
            if (pix_ready) x++;
            c++;
            if (x < npix) @(negedge clk);
        end
        if (npix == LW) begin
            @(negedge clk);
            n_checks++;
            if (frame_done !== (y == NL-1)) begin
                n_errors++;
                $display("FAIL frame_done after line y=%0d: got %b required %b", y, frame_done, y == NL-1);
            end
        end
        #1 pix_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if (drawline !== 1'b1) begin n_errors++; $display("FAIL reset_drawline: got %b required 1", drawline); end
        n_checks++;
        if ({pix_valid, pix_sol, pix_eol, pix_sof, pix_eof} !== 5'b0) begin
            n_errors++; $display("FAIL reset_pix: got %b required 00000", {pix_valid, pix_sol, pix_eol, pix_sof, pix_eof});
        end
        n_checks++;
        if ({overflow, frame_done, pix_data} !== 4'b0) begin
            n_errors++; $display("FAIL reset_misc: got %b required 0000", {overflow, frame_done, pix_data});
        end
    endtask

    task automatic test_basic_line();
        do_reset();
        write_line(0);
        n_checks++;
        if (drawline !== 1'b1) begin n_errors++; $display("FAIL basic_drawline: got %b required 1", drawline); end
        @(negedge clk);
        n_checks++;
        if (pix_valid !== 1'b0) begin n_errors++; $display("FAIL latency_n1: pix_valid got %b required 0", pix_valid); end
        @(negedge clk);
        n_checks++;
        if (pix_valid !== 1'b1) begin n_errors++; $display("FAIL latency_n2: pix_valid got %b required 1", pix_valid); end
        stream_line(0, 0, 1'b0, 8'hE4, LW, 2);
        @(negedge clk);
        n_checks++;
        if (pix_valid !== 1'b0) begin n_errors++; $display("FAIL basic_idle: pix_valid got %b required 0", pix_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        write_line(1);
        write_line(2);
        @(negedge clk);
        n_checks++;
        if ({drawline, overflow} !== 2'b00) begin
            n_errors++; $display("FAIL both_full {drawline,overflow}: got %b required 00", {drawline, overflow});
        end
        write_line(3);
        @(negedge clk);
        n_checks++;
        if ({drawline, overflow} !== 2'b01) begin
            n_errors++; $display("FAIL third_line {drawline,overflow}: got %b required 01", {drawline, overflow});
        end
        stream_line(1, 0, 1'b0, 8'hE4, LW, 4);
        n_checks++;
        if (drawline !== 1'b1) begin n_errors++; $display("FAIL drawline_freed: got %b required 1", drawline); end
        stream_line(2, 1, 1'b0, 8'hE4, LW, 4);
        n_checks++;
        if (overflow !== 1'b1) begin n_errors++; $display("FAIL overflow_sticky: got %b required 1", overflow); end
    endtask

    task automatic test_backpressure();
        do_reset();
        write_line(3);
        stream_line(3, 0, 1'b1, 8'hE4, LW, 4);
    endtask

    task automatic test_frame();
        do_reset();
        fork
            begin
                for (int l = 0; l < NL; l++) begin
                    int w = 0;
                    while (!drawline && w < 1000) begin @(posedge clk); #1; w++; end
                    n_checks++;
                    if (drawline !== 1'b1) begin
                        n_errors++; $display("FAIL writer_drawline line=%0d: got %b required 1", l, drawline);
                    end
                    write_line(l % 4);
                end
            end
            begin
                for (int l = 0; l < NL; l++) stream_line(l % 4, l, 1'b0, 8'hE4, LW, 400);
            end
        join
        n_checks++;
        if (overflow !== 1'b0) begin n_errors++; $display("FAIL frame_overflow: got %b required 0", overflow); end
        write_line(1);
        stream_line(1, 0, 1'b0, 8'hE4, LW, 4);
    endtask

    task automatic test_midline_reset();
        do_reset();
        write_line(2);
        stream_line(2, 0, 1'b0, 8'hE4, 80, 4);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({pix_valid, drawline, overflow, pix_sol} !== 4'b0100) begin
            n_errors++;
            $display("FAIL midline_reset {valid,drawline,overflow,sol}: got %b required 0100",
                     {pix_valid, drawline, overflow, pix_sol});
        end
        do_reset();
        write_line(3);
        stream_line(3, 0, 1'b0, 8'hE4, LW, 4);
    endtask

`ifdef SCANLINE_PALETTE_EN
    task automatic test_palette();
        do_reset();
        bgp = 8'h1B;
        write_line(0);
        fork
            stream_line(0, 0, 1'b0, 8'h1B, LW, 4);
            begin repeat (80) @(posedge clk); #2 bgp = 8'hE4; end
        join
        write_line(0);
        stream_line(0, 1, 1'b0, 8'hE4, LW, 4);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_line();
        test_overflow();
        test_backpressure();
        test_frame();
        test_midline_reset();
`ifdef SCANLINE_PALETTE_EN
        test_palette();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
